// File: rtl/crc_checker_if.sv
// Stream interface for the CRC-16 frame checker: frame input, result output and status.
// The checker uses the slave modport; the upstream/downstream side uses master.
interface crc_checker_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic [15:0]      in_crc;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic             crc_ok;
    logic [CNT_W-1:0] crc_err_cnt;
    logic             busy;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_crc,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output crc_ok,
        output crc_err_cnt,
        output busy
    );

    modport master (
        output in_valid,
        output in_data,
        output in_crc,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  crc_ok,
        input  crc_err_cnt,
        input  busy
    );
endinterface

// File: rtl/crc_checker.sv
// Serial CRC-16 (0x1021) frame checker: divides {data,crc} one bit per cycle and
// reports whether the remainder is zero, with a saturating bad-frame counter.
module crc_checker #(
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    crc_checker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [31:0]      sreg_q, sreg_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [15:0]      payload_q, payload_d;
    logic [15:0]      out_data_q, out_data_d;
    logic             crc_ok_q, crc_ok_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [15:0]      lfsr_step;
    logic             fb;

    // One step of the division: state' = x*state + bit (mod P).
    assign fb           = sreg_q[31] ^ lfsr_q[15];
    assign lfsr_step[0] = fb;

    for (genvar gi = 1; gi < 16; gi++) begin : g_lfsr
        if (gi == 5 || gi == 12) begin : g_tap
            assign lfsr_step[gi] = lfsr_q[gi-1] ^ lfsr_q[15];
        end else begin : g_shift
            assign lfsr_step[gi] = lfsr_q[gi-1];
        end
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        payload_d  = payload_q;
        out_data_d = out_data_q;
        crc_ok_d   = crc_ok_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sreg_d    = {bus.in_data, bus.in_crc};
                    lfsr_d    = 16'h0000;
                    cnt_d     = 6'd32;
                    payload_d = bus.in_data;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d = {sreg_q[30:0], 1'b0};
                lfsr_d = lfsr_step;
                cnt_d  = cnt_q - 6'd1;
                // Result registers only move here so they hold until the next frame's result.
                if (cnt_q == 6'd1) begin
                    state_d    = RESULT;
                    out_data_d = payload_q;
                    crc_ok_d   = (lfsr_step == 16'h0000);
                    if (lfsr_step != 16'h0000 && err_cnt_q != CNT_MAX) begin
                        err_cnt_d = err_cnt_q + CNT_ONE;
                    end
                end
            end
            RESULT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sreg_q     <= 32'h0;
            lfsr_q     <= 16'h0;
            cnt_q      <= 6'd0;
            payload_q  <= 16'h0;
            out_data_q <= 16'h0;
            crc_ok_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            payload_q  <= payload_d;
            out_data_q <= out_data_d;
            crc_ok_q   <= crc_ok_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == RESULT);
    assign bus.busy        = (state_q != IDLE);
    assign bus.out_data    = out_data_q;
    assign bus.crc_ok      = crc_ok_q;
    assign bus.crc_err_cnt = err_cnt_q;
endmodule

// File: tb/tb_crc_checker.sv
// Bench for crc_checker: directed frames plus random traffic, checked every cycle
// against a timing/polynomial-division model; a CNT_W=2 copy checks counter saturation.
module tb_crc_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data  = 16'h0;
    logic [15:0] in_crc   = 16'h0;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    crc_checker_if #(.CNT_W(8)) bus8 ();
    crc_checker_if #(.CNT_W(2)) bus2 ();

    assign bus8.in_valid  = in_valid;
    assign bus8.in_data   = in_data;
    assign bus8.in_crc    = in_crc;
    assign bus8.out_ready = out_ready;
    assign bus2.in_valid  = in_valid;
    assign bus2.in_data   = in_data;
    assign bus2.in_crc    = in_crc;
    assign bus2.out_ready = out_ready;

    crc_checker #(.CNT_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    crc_checker #(.CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // GF(2) long division of a 32-bit message by x^16+x^12+x^5+1.
    function automatic logic [15:0] poly_rem(logic [31:0] msg);
        logic [32:0] r;
        logic [32:0] p;
        r = {1'b0, msg};
        for (int i = 31; i >= 16; i--) begin
            if (r[i]) begin
                p = 33'h11021 << (i - 16);
                r = r ^ p;
            end
        end
        return r[15:0];
    endfunction

    // Behavioural model: frame accepted at cycle A is reported from cycle A+32 until released.
    int          cyc = 0;
    bit          m_busy = 0;
    int          m_acc = 0;
    logic [15:0] m_pay = 0;
    bit          m_pok = 0;
    logic [15:0] m_out_data = 0;
    bit          m_ok = 0;
    int          m_cnt8 = 0;
    int          m_cnt2 = 0;
    bit          chk_en = 0;
    bit          rec_en = 0;
    int          acc_q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy     = 0;
            m_out_data = 0;
            m_ok       = 0;
            m_cnt8     = 0;
            m_cnt2     = 0;
        end else begin
            cyc++;
            if (rec_en && bus8.in_valid && bus8.in_ready) acc_q.push_back(cyc);
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy = 1;
                    m_acc  = cyc;
                    m_pay  = in_data;
                    m_pok  = (poly_rem({in_data, in_crc}) == 16'h0);
                end
            end else if (cyc == m_acc + 32) begin
                m_out_data = m_pay;
                m_ok       = m_pok;
                if (!m_pok) begin
                    if (m_cnt8 != 255) m_cnt8++;
                    if (m_cnt2 != 3)   m_cnt2++;
                end
            end else if (cyc > m_acc + 32 && out_ready) begin
                m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  {31'h0, bus8.in_ready},  {31'h0, !m_busy});
            chk("busy",      {31'h0, bus8.busy},      {31'h0, m_busy});
            chk("out_valid", {31'h0, bus8.out_valid}, {31'h0, (m_busy && cyc >= m_acc + 32)});
            chk("out_data",  {16'h0, bus8.out_data},  {16'h0, m_out_data});
            chk("crc_ok",    {31'h0, bus8.crc_ok},    {31'h0, m_ok});
            chk("err_cnt8",  {24'h0, bus8.crc_err_cnt}, m_cnt8);
            chk("err_cnt2",  {30'h0, bus2.crc_err_cnt}, m_cnt2);
            chk("out_valid2", {31'h0, bus2.out_valid}, {31'h0, bus8.out_valid});
        end
    end

    task automatic send_frame(input logic [15:0] d, input logic [15:0] c, input int hold,
                              input bit pulse_iv, input bit lit, input bit lit_ok);
        int guard;
        int lat;
        in_data   = d;
        in_crc    = c;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        guard = 0;
        while (!bus8.in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            chk("accept_timeout", 32'd1, 32'd0);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 32'd32);
        if (lit) begin
            chk("lit_out_data", {16'h0, bus8.out_data}, {16'h0, d});
            chk("lit_crc_ok",   {31'h0, bus8.crc_ok},   {31'h0, lit_ok});
        end
        for (int i = 0; i < hold; i++) begin
            if (pulse_iv) in_valid = ~in_valid;
            @(posedge clk); #1;
            if (pulse_iv) chk("hold_in_ready", {31'h0, bus8.in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        chk("watchdog", 32'd1, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [15:0] d;
        logic [15:0] c;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'h0, bus8.in_ready},   32'd1);
        chk("rst_busy",      {31'h0, bus8.busy},       32'd0);
        chk("rst_out_valid", {31'h0, bus8.out_valid},  32'd0);
        chk("rst_out_data",  {16'h0, bus8.out_data},   32'd0);
        chk("rst_crc_ok",    {31'h0, bus8.crc_ok},     32'd0);
        chk("rst_err_cnt",   {24'h0, bus8.crc_err_cnt}, 32'd0);
        rst    = 1'b1;
        chk_en = 1'b1;

        // Hand-derived remainders pin the division model.
        chk("model_0001_1021", {16'h0, poly_rem(32'h0001_1021)}, 32'h0);
        chk("model_crc_0100",  {16'h0, poly_rem(32'h0100_0000)}, 32'h3331);
        chk("model_crc_0002",  {16'h0, poly_rem(32'h0002_0000)}, 32'h2042);
        chk("model_0001_1020", {16'h0, poly_rem(32'h0001_1020)}, 32'h1);

        send_frame(16'h0001, 16'h1021, 0, 0, 1, 1);
        chk("cnt_after_good", {24'h0, bus8.crc_err_cnt}, 32'd0);
        send_frame(16'h0100, 16'h3331, 0, 0, 1, 1);
        send_frame(16'h0002, 16'h2042, 0, 0, 1, 1);

        send_frame(16'h0001, 16'h1020, 0, 0, 1, 0);
        chk("cnt_first_bad", {24'h0, bus8.crc_err_cnt}, 32'd1);
        for (int i = 0; i < 3; i++) send_frame(16'h0001, 16'h1020, 0, 0, 1, 0);
        chk("cnt2_saturated", {30'h0, bus2.crc_err_cnt}, 32'd3);
        chk("cnt8_four",      {24'h0, bus8.crc_err_cnt}, 32'd4);

        send_frame(16'hBEEF, poly_rem(32'hBEEF_0000), 10, 1, 1, 1);

        // Reset in the middle of SHIFT drops the frame.
        in_data  = 16'h1234;
        in_crc   = 16'h0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy",      {31'h0, bus8.busy},        32'd0);
        chk("midrst_out_valid", {31'h0, bus8.out_valid},   32'd0);
        chk("midrst_err_cnt",   {24'h0, bus8.crc_err_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        send_frame(16'h0000, 16'h0000, 0, 0, 1, 1);

        // Back-to-back frames with in_valid and out_ready held high.
        acc_q.delete();
        rec_en    = 1'b1;
        in_data   = 16'h5A5A;
        in_crc    = poly_rem(32'h5A5A_0000);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (34 * 4 + 4) begin @(posedge clk); #1; end
        in_valid  = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        rec_en    = 1'b0;
        chk("b2b_accepts", (acc_q.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 1; i < acc_q.size(); i++) begin
            chk("b2b_spacing", acc_q[i] - acc_q[i-1], 32'd34);
        end

        for (int n = 0; n < 40; n++) begin
            d = 16'($urandom);
            c = poly_rem({d, 16'h0});
            case ($urandom_range(0, 2))
                0: c = c ^ (16'h1 << $urandom_range(0, 15));
                1: c = 16'($urandom);
                default: ;
            endcase
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send_frame(d, c, int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)), 0, 0);
        end
        repeat (5) begin @(posedge clk); #1; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
